// File: rtl/hack_memory_map.sv
// hack_memory_map: decodes the CPU data space into data RAM, screen RAM and a keyboard register.
// Define SCREEN_SCAN_EN to build the display scan engine and the second screen read port.
module hack_memory_map #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned RAM_WORDS    = 16384,
  parameter int unsigned SCREEN_WORDS = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  output logic [DATA_W-1:0] out,
  output logic              addr_fault,
  input  logic [DATA_W-1:0] kbd_code,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic              scan_ready,
  output logic              scan_frame_start
);

  localparam int unsigned KBD_ADDR = RAM_WORDS + SCREEN_WORDS;
  localparam int unsigned RAM_AW   = $clog2(RAM_WORDS);
  localparam int unsigned SCR_AW   = $clog2(SCREEN_WORDS);

  logic [31:0]       addr_ext;
  logic              sel_ram;
  logic              sel_scr;
  logic              sel_kbd;
  logic              sel_none;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic [DATA_W-1:0] key_reg;

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [DATA_W-1:0] scr [SCREEN_WORDS];

  // Address decode
  assign addr_ext = 32'(address);
  assign sel_ram  = (addr_ext < RAM_WORDS);
  assign sel_scr  = !sel_ram && (addr_ext < KBD_ADDR);
  assign sel_kbd  = (addr_ext == KBD_ADDR);
  assign sel_none = (addr_ext > KBD_ADDR);
  assign ram_idx  = RAM_AW'(addr_ext);
  assign scr_idx  = SCR_AW'(addr_ext - RAM_WORDS);

  // Memory write ports; contents survive reset
  always_ff @(posedge clk) begin
    if (load && sel_ram) ram[ram_idx] <= in;
    if (load && sel_scr) scr[scr_idx] <= in;
  end

  // Registered CPU read; array reads see pre-edge contents (read-before-write)
  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= '0;
      addr_fault <= 1'b0;
    end else begin
      addr_fault <= sel_none;
      if (sel_ram)      out <= ram[ram_idx];
      else if (sel_scr) out <= scr[scr_idx];
      else if (sel_kbd) out <= key_reg;
      else              out <= '0;
    end
  end

  // Key register: a CPU write acknowledges (clears) and takes priority over capture
  assign kbd_ready = (key_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg <= '0;
    end else if (sel_kbd && load) begin
      key_reg <= '0;
    end else if (kbd_valid && kbd_ready) begin
      key_reg <= kbd_code;
    end
  end

`ifdef SCREEN_SCAN_EN
  logic [SCR_AW-1:0] scan_ptr;
  logic              scan_adv;

  assign scan_adv = !scan_valid || scan_ready;

  // Scan engine: streams screen words in order, holding while video stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_ptr         <= '0;
      scan_valid       <= 1'b0;
      scan_data        <= '0;
      scan_frame_start <= 1'b0;
    end else if (scan_adv) begin
      scan_data        <= scr[scan_ptr];
      scan_frame_start <= (scan_ptr == '0);
      scan_valid       <= 1'b1;
      scan_ptr         <= (scan_ptr == SCR_AW'(SCREEN_WORDS - 1)) ? '0 : scan_ptr + SCR_AW'(1);
    end
  end
`else
  logic unused_scan_ready;

  assign unused_scan_ready = scan_ready;
  assign scan_data         = '0;
  assign scan_valid        = 1'b0;
  assign scan_frame_start  = 1'b0;
`endif

endmodule

// File: tb/tb_hack_memory_map.sv
// tb_hack_memory_map: randomized scoreboard bench for hack_memory_map against a word-level model.
// Scan checks apply when SCREEN_SCAN_EN is defined; otherwise the scan outputs must stay 0.
module tb_hack_memory_map;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned RAM_WORDS    = 16384;
  localparam int unsigned SCREEN_WORDS = 8192;
  localparam int          KBD_ADDR     = RAM_WORDS + SCREEN_WORDS;
  localparam int          ADDR_MAX     = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] in = '0;
  logic [ADDR_W-1:0] address = '0;
  logic              load = 1'b0;
  logic [DATA_W-1:0] out;
  logic              addr_fault;
  logic [DATA_W-1:0] kbd_code = '0;
  logic              kbd_valid = 1'b0;
  logic              kbd_ready;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic              scan_ready = 1'b1;
  logic              scan_frame_start;

  hack_memory_map #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_WORDS(RAM_WORDS), .SCREEN_WORDS(SCREEN_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .address(address), .load(load), .out(out),
    .addr_fault(addr_fault), .kbd_code(kbd_code), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .scan_data(scan_data), .scan_valid(scan_valid), .scan_ready(scan_ready),
    .scan_frame_start(scan_frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] out;
    logic              fault;
    logic              ready;
    logic              chk_out;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] mem_m [int];
  logic [DATA_W-1:0] key_m = '0;
  int                checks = 0;
  int                errors = 0;
  int                wr_off = -1;
  logic              wr_known = 1'b0;
  logic [DATA_W-1:0] wr_old = '0;

  // One CPU cycle: drive inputs and push the response the model expects after the edge
  task automatic step(input int a, input bit ld, input logic [DATA_W-1:0] d, input bit kv,
                      input logic [DATA_W-1:0] kc, input bit rst, input bit sr);
    exp_t e;
    @(negedge clk);
    reset = rst; address = ADDR_W'(a); load = ld; in = d;
    kbd_valid = kv; kbd_code = kc; scan_ready = sr;
    wr_off = -1; wr_known = 1'b0;
    e.out = '0; e.fault = 1'b0; e.chk_out = 1'b1;
    if (rst) begin
      key_m = '0;
    end else if (a == KBD_ADDR) begin
      e.out = key_m;
      if (ld) key_m = '0;
      else if (kv && key_m == 0) key_m = kc;
    end else begin
      if (a < KBD_ADDR) begin
        if (mem_m.exists(a)) e.out = mem_m[a];
        else e.chk_out = 1'b0;
        if (ld && a >= RAM_WORDS) begin
          wr_off = a - RAM_WORDS;
          wr_known = mem_m.exists(a);
          if (wr_known) wr_old = mem_m[a];
        end
        if (ld) mem_m[a] = d;
      end else begin
        e.fault = 1'b1;
      end
      if (kv && key_m == 0) key_m = kc;
    end
    e.ready = (key_m == 0);
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit sr);
    for (int i = 0; i < n; i++) step(0, 1'b0, '0, 1'b0, '0, 1'b0, sr);
  endtask

  function automatic int pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)       return $urandom_range(0, 15);
    else if (r < 6)  return RAM_WORDS + $urandom_range(0, 15);
    else if (r == 6) return KBD_ADDR - 1 - $urandom_range(0, 7);
    else if (r < 9)  return KBD_ADDR;
    else             return $urandom_range(KBD_ADDR + 1, ADDR_MAX);
  endfunction

  // CPU-side monitor
  always @(posedge clk) begin : cpu_mon
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk_out) begin
        checks++;
        if (out !== e.out) begin
          errors++;
          $display("FAIL out: got %h expected %h at %0t", out, e.out, $time);
        end
      end
      checks++;
      if (addr_fault !== e.fault) begin
        errors++;
        $display("FAIL addr_fault: got %b expected %b at %0t", addr_fault, e.fault, $time);
      end
      checks++;
      if (kbd_ready !== e.ready) begin
        errors++;
        $display("FAIL kbd_ready: got %b expected %b at %0t", kbd_ready, e.ready, $time);
      end
    end
  end

  // Scan-side monitor: tracks the expected offset stream
  int                exp_off = 0;
  logic              prev_valid = 1'b0;
  logic              last_known = 1'b0;
  logic [DATA_W-1:0] last_ev = '0;
  logic              last_fs = 1'b0;

  always @(posedge clk) begin : scan_mon
    logic              rst_e;
    logic              rdy_e;
    logic              kn;
    logic [DATA_W-1:0] ev;
    int                a;
    rst_e = reset;
    rdy_e = scan_ready;
    #1;
`ifdef SCREEN_SCAN_EN
    if (rst_e) begin
      checks++;
      if (scan_valid !== 1'b0 || scan_data !== '0 || scan_frame_start !== 1'b0) begin
        errors++;
        $display("FAIL scan_reset: got v=%b d=%h fs=%b expected 0 0 0 at %0t",
                 scan_valid, scan_data, scan_frame_start, $time);
      end
      exp_off = 0;
    end else begin
      checks++;
      if (scan_valid !== 1'b1) begin
        errors++;
        $display("FAIL scan_valid: got %b expected 1 at %0t", scan_valid, $time);
      end
      if (!prev_valid || rdy_e) begin
        a = RAM_WORDS + exp_off;
        ev = '0;
        if (wr_off == exp_off) begin
          kn = wr_known;
          ev = wr_old;
        end else begin
          kn = mem_m.exists(a);
          if (kn) ev = mem_m[a];
        end
        last_known = kn;
        last_ev = ev;
        last_fs = (exp_off == 0);
        exp_off = (exp_off + 1) % SCREEN_WORDS;
      end
      checks++;
      if (scan_frame_start !== last_fs) begin
        errors++;
        $display("FAIL scan_frame_start: got %b expected %b at %0t", scan_frame_start, last_fs, $time);
      end
      if (last_known) begin
        checks++;
        if (scan_data !== last_ev) begin
          errors++;
          $display("FAIL scan_data: got %h expected %h at %0t", scan_data, last_ev, $time);
        end
      end
    end
    prev_valid = scan_valid;
`else
    checks++;
    if (scan_valid !== 1'b0 || scan_data !== '0 || scan_frame_start !== 1'b0) begin
      errors++;
      $display("FAIL scan_tied: got v=%b d=%h fs=%b expected 0 0 0 at %0t",
               scan_valid, scan_data, scan_frame_start, $time);
    end
`endif
  end

  initial begin
    bit kv;
    bit ld;
    bit rst;
    logic [DATA_W-1:0] kc;
    step(0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    step(0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    // Give every address the random phase uses a known value
    for (int i = 0; i < 16; i++) begin
      step(i, 1'b1, DATA_W'($urandom), 1'b0, '0, 1'b0, 1'b1);
      step(RAM_WORDS + i, 1'b1, DATA_W'($urandom), 1'b0, '0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 8; i++) step(KBD_ADDR - 1 - i, 1'b1, DATA_W'($urandom), 1'b0, '0, 1'b0, 1'b1);

    // Write then read, and same-cycle read+write returning old data
    step(5, 1'b1, 16'h1234, 1'b0, '0, 1'b0, 1'b1);
    step(5, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(5, 1'b1, 16'hBEEF, 1'b0, '0, 1'b0, 1'b1);
    step(5, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

    // Keyboard capture, ignored second key, acknowledge, recapture
    step(0, 1'b0, '0, 1'b1, 16'h0041, 1'b0, 1'b1);
    step(KBD_ADDR, 1'b0, '0, 1'b1, 16'h0042, 1'b0, 1'b1);
    step(KBD_ADDR, 1'b1, 16'h7777, 1'b1, 16'h0042, 1'b0, 1'b1);
    step(0, 1'b0, '0, 1'b1, 16'h0042, 1'b0, 1'b1);
    step(KBD_ADDR, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(KBD_ADDR, 1'b1, '0, 1'b0, '0, 1'b0, 1'b1);

    // Unmapped access faults for one cycle and leaves memory alone
    step(KBD_ADDR + 1, 1'b1, 16'hDEAD, 1'b0, '0, 1'b0, 1'b1);
    step(KBD_ADDR + 1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(5, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(ADDR_MAX, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(KBD_ADDR - 1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

    // Full frame plus wrap with markers at both ends of the screen
    step(RAM_WORDS, 1'b1, 16'hAAAA, 1'b0, '0, 1'b0, 1'b1);
    step(KBD_ADDR - 1, 1'b1, 16'h5555, 1'b0, '0, 1'b0, 1'b1);
    step(0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle(2 * SCREEN_WORDS + 8, 1'b1);

    // Mid-frame stall, then reset during a stall
    idle(3, 1'b0);
    idle(5, 1'b1);
    idle(2, 1'b0);
    step(0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Randomized traffic on all ports
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      ld  = !rst && ($urandom_range(0, 1) == 1);
      kv  = ($urandom_range(0, 2) == 0);
      kc  = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
      step(pick_addr(), ld, DATA_W'($urandom), kv, kc, rst, $urandom_range(0, 2) != 0);
    end
    idle(4, 1'b1);
    @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_memory_map.md
# hack_memory_map

Parametrised successor to the CPU data-memory block. It decodes one CPU address space into data RAM, screen RAM and a keyboard register. It adds a valid/ready keyboard capture handshake, out-of-range fault reporting and an optional display scan engine that streams screen words to the video block over a second read port. It sits between the CPU data port and the keyboard/video peripherals.

## Interface
- DATA_W, 16, word width of RAM, screen, keyboard and all data ports
- ADDR_W, 15, CPU address width
- RAM_WORDS, 16384, data RAM size; occupies addresses 0..RAM_WORDS-1
- SCREEN_WORDS, 8192, screen RAM size; occupies RAM_WORDS..RAM_WORDS+SCREEN_WORDS-1
- KBD_ADDR (derived, not overridable) = RAM_WORDS+SCREEN_WORDS

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  single rising-edge clock for all state
- reset  in  1  synchronous, active-high reset
- in  in  DATA_W  CPU write data
- address  in  ADDR_W  CPU word address
- load  in  1  CPU write enable
- out  out  DATA_W  registered CPU read data
- addr_fault  out  1  one-cycle pulse, aligned with out, for an access above KBD_ADDR
- kbd_code  in  DATA_W  key code from keyboard front end
- kbd_valid  in  1  kbd_code is valid
- kbd_ready  out  1  key register is empty and can accept a code
- scan_data  out  DATA_W  screen word to video (SCREEN_SCAN_EN only)
- scan_valid  out  1  scan_data is valid
- scan_ready  in  1  video accepts scan_data
- scan_frame_start  out  1  high while scan_data holds screen offset 0

## Operation
- Decode: address < RAM_WORDS → RAM; < KBD_ADDR → screen at offset address-RAM_WORDS; == KBD_ADDR → keyboard; above KBD_ADDR → unmapped.
- RAM/screen: load=1 writes in on the rising clk edge. Every access registers the addressed word into out. A read and a write to the same word in the same cycle return the old data (read-before-write).
- Keyboard register key_reg: kbd_ready = (key_reg == 0). kbd_valid && kbd_ready captures kbd_code. A CPU read returns key_reg without clearing it. A CPU write (load=1, any data) clears key_reg to 0, which acknowledges the key. A capture of code 0 is a no-op.
- Clear and kbd_valid in the same cycle: kbd_ready is already 0, so there is no capture. key_reg becomes 0 and kbd_ready rises the next cycle.
- Unmapped: writes are ignored and out is 0. addr_fault=1 for the following cycle (registered).
- Scan engine: pointer scan_ptr runs 0..SCREEN_WORDS-1. On every edge where !scan_valid || scan_ready:
  - scan_data ← screen[scan_ptr]
  - scan_frame_start ← (scan_ptr == 0)
  - scan_valid ← 1
  - scan_ptr ← scan_ptr+1, wrapping to 0 after SCREEN_WORDS-1
- Scan stall: while scan_valid && !scan_ready, scan_data, scan_frame_start and scan_ptr hold. Scan reads of a word the CPU writes in the same edge return old data.

## Timing
- Reset values: out=0, addr_fault=0, key_reg=0 (kbd_ready=1), scan_ptr=0, scan_valid=0, scan_data=0, scan_frame_start=0. RAM and screen contents are not cleared.
- Reset mid-operation: all of the above apply on the next edge. An in-flight scan word and any pending key are dropped.
- CPU read latency: 1 cycle (address at edge N → out valid after edge N).
- Write visible to a read issued on the next cycle.
- Keyboard: code captured at edge N; readable at KBD_ADDR from the access at edge N+1; kbd_ready low after edge N.
- Scan: scan_valid first rises after the first edge with reset=0, carrying offset 0 with scan_frame_start=1. Sustained throughput is 1 word/cycle while scan_ready=1.

## Configuration
- SCREEN_SCAN_EN defined: scan engine and second screen read port are built.
- SCREEN_SCAN_EN undefined: scan_data, scan_valid and scan_frame_start are tied 0, scan_ready is ignored and the screen RAM is single-port. CPU behaviour is identical in both builds.

## Test plan
- Reset, write 0x1234 to address 5, read 5 next cycle → out=0x1234 one cycle after the read. Same-cycle read+write of 0xBEEF to 5 → out=0x1234.
- kbd_code=0x0041, kbd_valid=1 → kbd_ready=0; CPU read of 24576 → out=0x0041. Second code 0x0042 offered and ignored. CPU write to 24576 → kbd_ready=1 next cycle, then 0x0042 captured.
- Read and write at 24577 → out=0, addr_fault=1 for exactly one cycle, memory unchanged.
- SCREEN_SCAN_EN defined: preload screen[0]=0xAAAA and screen[8191]=0x5555, hold scan_ready=1 → word 0 with frame_start=1, then 8191 words later 0x5555, then 0xAAAA with frame_start=1 again (wrap).
- SCREEN_SCAN_EN defined: drop scan_ready for 3 cycles mid-frame → scan_data stable and no word skipped or duplicated. Assert reset during the stall → scan_valid=0 next cycle and the restart is at offset 0.
